// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, presents a start bit and
// shifts out one odd-parity frame on the device's clock, then checks the ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 120,
   parameter int TIMEOUT_CYCLES = 15000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2clk_in,
   input  logic       ps2dat_in,
   output logic       ps2clk_oe,
   output logic       ps2dat_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SEND,
      WAIT_IDLE,
      FINISH
   } state_t;

   state_t           state;
   logic             clk_meta;
   logic             clk_s;
   logic             clk_s_prev;
   logic             dat_meta;
   logic             dat_s;
   logic             fall;
   logic             to_hit;
   logic [9:0]       frame;
   logic [3:0]       n;
   logic [3:0]       n_next;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;

   // Pad synchronizers; reset to the idle-high bus level so no false edge appears.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta   <= 1'b1;
         clk_s      <= 1'b1;
         clk_s_prev <= 1'b1;
         dat_meta   <= 1'b1;
         dat_s      <= 1'b1;
      end else begin
         clk_meta   <= ps2clk_in;
         clk_s      <= clk_meta;
         clk_s_prev <= clk_s;
         dat_meta   <= ps2dat_in;
         dat_s      <= dat_meta;
      end
   end

   assign fall   = clk_s_prev & ~clk_s;
   assign n_next = n + 4'd1;
   assign to_hit = (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ps2clk_oe <= 1'b0;
         ps2dat_oe <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         timeout   <= 1'b0;
         frame     <= '0;
         n         <= '0;
         inh_cnt   <= '0;
         to_cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               ps2clk_oe <= 1'b0;
               ps2dat_oe <= 1'b0;
               busy      <= 1'b0;
               if (tx_start) begin
                  frame     <= {1'b1, ~^tx_data, tx_data};
                  busy      <= 1'b1;
                  ack_err   <= 1'b0;
                  timeout   <= 1'b0;
                  n         <= '0;
                  inh_cnt   <= '0;
                  to_cnt    <= '0;
                  ps2clk_oe <= 1'b1;
                  state     <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (inh_cnt == INH_LAST) begin
                  ps2dat_oe <= 1'b1;
                  state     <= START;
               end else begin
                  inh_cnt <= inh_cnt + INH_ONE;
               end
            end

            START: begin
               ps2clk_oe <= 1'b0;
               n         <= '0;
               to_cnt    <= '0;
               state     <= SEND;
            end

            // Each device falling edge shifts out the next frame bit; the 11th is the ACK slot.
            SEND: begin
               if (to_hit) begin
                  ps2clk_oe <= 1'b0;
                  ps2dat_oe <= 1'b0;
                  timeout   <= 1'b1;
                  ack_err   <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= FINISH;
               end else if (fall) begin
                  to_cnt <= '0;
                  n      <= n_next;
                  if (n_next == 4'd11) begin
                     ack_err   <= dat_s;
                     ps2dat_oe <= 1'b0;
                     state     <= WAIT_IDLE;
                  end else begin
                     ps2dat_oe <= ~frame[0];
                     frame     <= {1'b0, frame[9:1]};
                  end
               end else begin
                  to_cnt <= to_cnt + TO_ONE;
               end
            end

            WAIT_IDLE: begin
               ps2clk_oe <= 1'b0;
               ps2dat_oe <= 1'b0;
               if (to_hit) begin
                  timeout <= 1'b1;
                  ack_err <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= FINISH;
               end else if (clk_s && dat_s) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end else if (fall) begin
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + TO_ONE;
               end
            end

            FINISH: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
